// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: datapath widths, opcode map and
// the layout of the microcode decoder address.
package cpu_pkg;

    localparam int PC_WIDTH      = 12;
    localparam int INSTR_WIDTH   = 8;
    localparam int OPCODE_WIDTH  = 4;
    localparam int OPERAND_WIDTH = 4;

    // Instruction set, encoded in instr[7:4]
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_JC    = 4'd0,
        OP_JNC   = 4'd1,
        OP_CMPI  = 4'd2,
        OP_CMPM  = 4'd3,
        OP_LIT   = 4'd4,
        OP_IN    = 4'd5,
        OP_LD    = 4'd6,
        OP_ST    = 4'd7,
        OP_JZ    = 4'd8,
        OP_JNZ   = 4'd9,
        OP_ADDI  = 4'd10,
        OP_ADDM  = 4'd11,
        OP_JMP   = 4'd12,
        OP_OUT   = 4'd13,
        OP_NANDI = 4'd14,
        OP_NANDM = 4'd15
    } opcode_t;

    // Instruction phase: every instruction is one fetch edge plus one execute edge
    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_t;

    // Decoder address layout: {opcode, C, Z, phase}
    localparam int ADDR_WIDTH     = 7;
    localparam int ADDR_PHASE_BIT = 0;
    localparam int ADDR_Z_BIT     = 1;
    localparam int ADDR_C_BIT     = 2;
    localparam int ADDR_OP_LSB    = 3;
    localparam int ADDR_OP_MSB    = 6;

    function automatic logic [ADDR_WIDTH-1:0] make_address(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic                    c,
        input logic                    z,
        input logic                    ph
    );
        logic [ADDR_WIDTH-1:0] a;
        a                           = '0;
        a[ADDR_OP_MSB:ADDR_OP_LSB]  = op;
        a[ADDR_C_BIT]               = c;
        a[ADDR_Z_BIT]               = z;
        a[ADDR_PHASE_BIT]           = ph;
        return a;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load has priority over increment, otherwise hold.
// Increment wraps naturally modulo 2^WIDTH.
module pc_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    // PC register with synchronous reset taking priority over enable
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= load_value;
            end else if (inc) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer feeding the microcode decoder ROM: holds the PC,
// phase flip-flop, fetch register and C/Z flags, and presents the decoder
// address {opcode, C, Z, phase}. All outputs are purely registered.
module fetch_sequencer #(
    parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic [PC_WIDTH-1:0]    pc_load_value,
    input  logic                   incPC,
    input  logic                   loadPC,
    input  logic                   loadFlags,
    input  logic                   alu_c,
    input  logic                   alu_z,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [3:0]             operand,
    output logic                   phase,
    output logic                   flag_c,
    output logic                   flag_z,
    output logic [6:0]             address
);

    import cpu_pkg::*;

    phase_t                 phase_q;
    phase_t                 phase_d;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   flag_c_q;
    logic                   flag_z_q;

    pc_counter #(
        .WIDTH (PC_WIDTH)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (loadPC),
        .inc        (incPC),
        .load_value (pc_load_value),
        .count      (pc)
    );

    // Phase state register
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_FETCH;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase next state: toggle on every enabled edge
    always_comb begin
        // NOTE: default assignment first so no path leaves phase_d
        // unassigned, which would otherwise infer a latch.
        phase_d = phase_q;
        if (en) begin
            phase_d = (phase_q == PH_FETCH) ? PH_EXEC : PH_FETCH;
        end
    end

    // Fetch register: capture the ROM word only on the fetch edge
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
        end else if (en && (phase_q == PH_FETCH)) begin
            instr_q <= rom_data;
        end
    end

    // Flags register: latch ALU flags on request, in either phase
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (en && loadFlags) begin
            flag_c_q <= alu_c;
            flag_z_q <= alu_z;
        end
    end

    assign instr   = instr_q;
    assign operand = instr_q[OPERAND_WIDTH-1:0];
    assign phase   = phase_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign address = make_address(instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH],
                                  flag_c_q, flag_z_q, phase_q);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. Each step drives one
// edge's inputs, pushes the expected post-edge state onto a scoreboard, and
// pops/compares it after the edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  rom_data;
    logic [11:0] pc_load_value;
    logic        incPC;
    logic        loadPC;
    logic        loadFlags;
    logic        alu_c;
    logic        alu_z;
    logic [11:0] pc;
    logic [7:0]  instr;
    logic [3:0]  operand;
    logic        phase;
    logic        flag_c;
    logic        flag_z;
    logic [6:0]  address;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [11:0] pc;
        logic [7:0]  instr;
        logic        phase;
        logic        c;
        logic        z;
    } exp_t;

    exp_t sb[$];

    // Reference state, advanced from the behavioural description
    logic [11:0] m_pc;
    logic [7:0]  m_instr;
    logic        m_phase;
    logic        m_c;
    logic        m_z;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .rom_data      (rom_data),
        .pc_load_value (pc_load_value),
        .incPC         (incPC),
        .loadPC        (loadPC),
        .loadFlags     (loadFlags),
        .alu_c         (alu_c),
        .alu_z         (alu_z),
        .pc            (pc),
        .instr         (instr),
        .operand       (operand),
        .phase         (phase),
        .flag_c        (flag_c),
        .flag_z        (flag_z),
        .address       (address)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, predict, push, clock, pop and compare
    task automatic step(input string tag, input logic rst, input logic e,
                        input logic [7:0] rd, input logic lp, input logic ip,
                        input logic [11:0] plv, input logic lf,
                        input logic c, input logic z);
        exp_t ex;
        exp_t got;
        reset         = rst;
        en            = e;
        rom_data      = rd;
        loadPC        = lp;
        incPC         = ip;
        pc_load_value = plv;
        loadFlags     = lf;
        alu_c         = c;
        alu_z         = z;
        if (rst) begin
            m_pc = '0; m_instr = '0; m_phase = 1'b0; m_c = 1'b0; m_z = 1'b0;
        end else if (e) begin
            if (lf) begin
                m_c = c;
                m_z = z;
            end
            if (lp)      m_pc = plv;
            else if (ip) m_pc = m_pc + 12'd1;
            if (!m_phase) m_instr = rd;
            m_phase = ~m_phase;
        end
        ex.tag = tag; ex.pc = m_pc; ex.instr = m_instr;
        ex.phase = m_phase; ex.c = m_c; ex.z = m_z;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, ".pc"},      32'(pc),      32'(got.pc));
        check({got.tag, ".instr"},   32'(instr),   32'(got.instr));
        check({got.tag, ".phase"},   32'(phase),   32'(got.phase));
        check({got.tag, ".flag_c"},  32'(flag_c),  32'(got.c));
        check({got.tag, ".flag_z"},  32'(flag_z),  32'(got.z));
        check({got.tag, ".operand"}, 32'(operand), 32'(got.instr[3:0]));
        check({got.tag, ".address"}, 32'(address),
              32'({got.instr[7:4], got.c, got.z, got.phase}));
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; rom_data = 8'hA5; pc_load_value = '0;
        incPC = 1'b0; loadPC = 1'b0; loadFlags = 1'b0; alu_c = 1'b0; alu_z = 1'b0;
        m_pc = '0; m_instr = '0; m_phase = 1'b0; m_c = 1'b0; m_z = 1'b0;
        @(posedge clk);
        #1;

        // Reset held two cycles with en=1 and live ROM data
        step("rst0", 1, 1, 8'hA5, 0, 0, 12'h000, 0, 0, 0);
        step("rst1", 1, 1, 8'hA5, 0, 0, 12'h000, 0, 0, 0);
        check("rst.address_lit", 32'(address), 32'(7'b0000_000));

        // First edge after release fetches A5
        step("rel", 0, 1, 8'hA5, 0, 0, 12'h000, 0, 0, 0);
        check("rel.address_lit", 32'(address), 32'(7'b1010_001));

        // Back to fetch, then sequential fetch of LIT 4'hF
        step("seq0", 0, 1, 8'h4F, 0, 0, 12'h000, 0, 0, 0);
        step("seq1", 0, 1, 8'h4F, 0, 0, 12'h000, 0, 0, 0);
        step("seq2", 0, 1, 8'h4F, 0, 1, 12'h000, 0, 0, 0);
        step("seq3", 0, 1, 8'h4F, 0, 0, 12'h000, 0, 0, 0);
        step("seq4", 0, 1, 8'h4F, 0, 1, 12'h000, 0, 0, 0);
        check("seq.pc_lit",      32'(pc),      32'(12'd2));
        check("seq.phase_lit",   32'(phase),   32'(1'b0));
        check("seq.operand_lit", 32'(operand), 32'(4'hF));

        // Jump: loadPC beats incPC on the execute edge
        step("jmp0", 0, 1, 8'hC0, 0, 0, 12'h000, 0, 0, 0);
        step("jmp1", 0, 1, 8'hC0, 1, 1, 12'h3C7, 0, 0, 0);
        check("jmp.pc_lit", 32'(pc), 32'(12'h3C7));

        // Wrap: load FFF on fetch edge, increment on execute edge
        step("wrap0", 0, 1, 8'h4F, 1, 0, 12'hFFF, 0, 0, 0);
        check("wrap.pc_fff", 32'(pc), 32'(12'hFFF));
        step("wrap1", 0, 1, 8'h4F, 0, 1, 12'h000, 0, 0, 0);
        check("wrap.pc_lit", 32'(pc), 32'(12'h000));

        // Flags: JC, latch C=1 Z=0 on execute, visible through next fetch
        step("flg0", 0, 1, 8'h03, 0, 0, 12'h000, 0, 0, 0);
        step("flg1", 0, 1, 8'h03, 0, 0, 12'h000, 1, 1, 0);
        check("flg.c_lit", 32'(flag_c), 32'(1'b1));
        check("flg.z_lit", 32'(flag_z), 32'(1'b0));
        step("flg2", 0, 1, 8'h03, 0, 0, 12'h000, 0, 0, 1);
        check("flg.address_lit", 32'(address), 32'(7'b0000_101));
        step("flg3", 0, 1, 8'h03, 0, 0, 12'h000, 0, 0, 1);
        check("flg.hold_c", 32'(flag_c), 32'(1'b1));
        check("flg.hold_z", 32'(flag_z), 32'(1'b0));

        // Set up pc=123 in execute, then stall with noisy control inputs
        step("stl0", 0, 1, 8'hB6, 1, 0, 12'h123, 0, 0, 0);
        step("stl1", 0, 0, 8'h7E, 1, 1, 12'h555, 1, 0, 1);
        step("stl2", 0, 0, 8'h91, 0, 1, 12'h000, 1, 1, 1);
        step("stl3", 0, 0, 8'h22, 1, 0, 12'hABC, 1, 0, 0);
        check("stl.pc_lit",    32'(pc),    32'(12'h123));
        check("stl.phase_lit", 32'(phase), 32'(1'b1));
        check("stl.instr_lit", 32'(instr), 32'(8'hB6));

        // Mid-instruction reset while executing
        step("mrst", 1, 1, 8'h4F, 1, 1, 12'h777, 1, 1, 1);
        check("mrst.pc_lit",    32'(pc),      32'(12'h000));
        check("mrst.phase_lit", 32'(phase),   32'(1'b0));
        check("mrst.flags_lit", 32'({flag_c, flag_z}), 32'(2'b00));
        step("restart", 0, 1, 8'h5A, 0, 0, 12'h000, 0, 0, 0);

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the microcode decoder ROM `tabla` in the 4-bit CPU.
- Holds the program counter, the phase flip-flop, the fetch (instruction) register and the C/Z flags register.
- Presents the 7-bit decoder address {opcode[3:0], C, Z, phase}.
- Consumes the decoder's PC/flag control signals and the ALU flag outputs, closing the fetch/execute loop.

Parameters:
- PC_WIDTH, 12, program counter / program ROM address width.
- INSTR_WIDTH, 8, program ROM word width: opcode = [7:4], operand = [3:0].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  step enable; low freezes all state.
- rom_data  input  INSTR_WIDTH  program ROM output for address pc.
- pc_load_value  input  PC_WIDTH  jump target.
- incPC  input  1  decoder: increment PC.
- loadPC  input  1  decoder: load PC from pc_load_value.
- loadFlags  input  1  decoder: latch ALU flags.
- alu_c  input  1  ALU carry out.
- alu_z  input  1  ALU zero out.
- pc  output  PC_WIDTH  program counter, drives program ROM address.
- instr  output  INSTR_WIDTH  fetch register contents.
- operand  output  4  instr[3:0].
- phase  output  1  0 = fetch, 1 = execute.
- flag_c  output  1  registered carry.
- flag_z  output  1  registered zero.
- address  output  7  decoder address = {instr[7:4], flag_c, flag_z, phase}; bit 6 = opcode MSB, bit 0 = phase.

Behaviour:
- Reset is synchronous, active-high and has priority over en.
- Reset values: pc=0, instr=0, phase=0, flag_c=0, flag_z=0, hence address=7'b0000_000.
- All outputs come straight from registers or from slicing/concatenating them; no combinational path from inputs to outputs.
- en low: every register holds, including phase. Control inputs are ignored.
- en high, each edge:
  - phase toggles.
  - instr <= rom_data only when the current phase == 0 (fetch). It holds during execute.
  - PC update: loadPC=1 gives pc <= pc_load_value. Otherwise incPC=1 gives pc <= pc+1, modulo 2^PC_WIDTH (12'hFFF wraps to 0). Otherwise pc holds.
  - loadPC and incPC both high: loadPC wins.
  - loadFlags=1: flag_c <= alu_c and flag_z <= alu_z. Otherwise both hold.
  - PC and flag updates are honoured in either phase. Gating by phase is the decoder's responsibility.
- Latency: a new opcode is visible on address one cycle after the fetch edge, with phase=1. Flags written on an execute edge are visible at the next fetch.
- Reset asserted mid-instruction, either phase: the next edge returns everything to the reset values. Execution restarts at pc=0 in fetch.

Decomposition:
- Shared package `cpu_pkg` holds:
  - PC_WIDTH and INSTR_WIDTH.
  - 4-bit opcode constants: JC=0, JNC=1, CMPI=2, CMPM=3, LIT=4, IN=5, LD=6, ST=7, JZ=8, JNZ=9, ADDI=10, ADDM=11, JMP=12, OUT=13, NANDI=14, NANDM=15.
  - Decoder address field positions.
- One sub-module, `pc_counter` (load/increment/hold with load priority, enable, synchronous reset). Phase, fetch and flag registers stay inline.

Test Plan:
- Reset: hold reset 2 cycles with en=1 and rom_data=8'hA5 -> pc=0, instr=0, phase=0, address=7'b0000_000. Release -> first edge sets instr=8'hA5 and phase=1, giving address=7'b1010_001.
- Sequential fetch: rom_data=8'h4F, incPC=1 on execute edges only -> after 4 edges pc=2 and phase=0. Operand=4'hF while opcode 4 is held.
- Jump priority: in execute, loadPC=1, incPC=1, pc_load_value=12'h3C7 -> pc=12'h3C7 next cycle (not pc+1).
- Wrap: pc=12'hFFF with incPC=1 -> pc=12'h000.
- Flags: opcode 0 (JC); loadFlags=1 with alu_c=1, alu_z=0 on an execute edge -> next fetch shows flag_c=1, flag_z=0. Following execute shows address=7'b0000_101. loadFlags=0 -> flags hold.
- Stall and mid-run reset: en=0 for 3 cycles -> no register changes. Reset asserted while phase=1 and pc=12'h123 -> next edge gives pc=0, phase=0, flags=0.
